// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-channel TDM receive demultiplexer.
//   NUM_SLOTS : channels per frame
//   SLOT_W    : width of the slot index
//   state_t   : slot controller state encoding
package tdm_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_ctrl.sv
// Slot controller for the TDM demultiplexer: tracks frame position, issues
// per-slot shadow write enables and the commit strobe, and generates the
// frame_valid / frame_err pulses.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : input word qualifier
//   in_sof        : slot-0 marker (only meaningful with in_valid)
//   sel           : slot the next accepted non-SOF word fills (registered)
//   wr_en         : per-slot shadow write enable (combinational)
//   commit        : slot-7 word accepted, copy frame to outputs (combinational)
//   frame_valid   : one-cycle pulse after commit
//   frame_err     : one-cycle pulse after stray word or short frame
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for SOF; non-SOF words are dropped and flagged
// COLLECT | slot 0 captured, filling slots sel..7; SOF restarts frame
module tdm_slot_ctrl
  import tdm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  output logic [SLOT_W-1:0]    sel,
  output logic [NUM_SLOTS-1:0] wr_en,
  output logic                 commit,
  output logic                 frame_valid,
  output logic                 frame_err
);

  state_t            state, state_d;
  logic [SLOT_W-1:0] sel_d;
  logic              err_set;

  // state register, slot counter and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_d;
      sel         <= sel_d;
      frame_valid <= commit;
      frame_err   <= err_set;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (in_valid && in_sof)
          state_d = COLLECT;
      end
      COLLECT: begin
        if (in_valid && !in_sof && sel == LAST_SLOT)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs: write enables, commit, error, next slot index
  always_comb begin
    wr_en   = '0;
    commit  = 1'b0;
    err_set = 1'b0;
    sel_d   = sel;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            wr_en[0] = 1'b1;
            sel_d    = SLOT_W'(1);
          end else begin
            err_set = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (in_sof) begin
            // short frame: flag it and restart with this word as slot 0
            err_set  = 1'b1;
            wr_en[0] = 1'b1;
            sel_d    = SLOT_W'(1);
          end else begin
            wr_en[sel] = 1'b1;
            if (sel == LAST_SLOT) begin
              commit = 1'b1;
              sel_d  = '0;
            end else begin
              sel_d = sel + SLOT_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tdm_demux_8x8.sv
// Receive-side 8-channel TDM demultiplexer. Words arrive one slot per
// accepted cycle, slot 0 flagged by in_sof. A full frame is gathered in a
// shadow buffer and committed to data0..data7 atomically.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid        : in_data/in_sof qualified this cycle
//   in_sof          : marks the slot-0 word
//   in_data         : slot word
//   data0..data7    : committed channel values (registered)
//   frame_valid     : one-cycle pulse, data0..data7 just updated
//   frame_err       : one-cycle pulse, stray word or short frame
//   sel             : slot the next accepted non-SOF word fills
module tdm_demux_8x8
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  data0,
  output logic [WIDTH-1:0]  data1,
  output logic [WIDTH-1:0]  data2,
  output logic [WIDTH-1:0]  data3,
  output logic [WIDTH-1:0]  data4,
  output logic [WIDTH-1:0]  data5,
  output logic [WIDTH-1:0]  data6,
  output logic [WIDTH-1:0]  data7,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [SLOT_W-1:0] sel
);

  logic [NUM_SLOTS-1:0] wr_en;
  logic                 commit;
  logic [WIDTH-1:0]     shadow [NUM_SLOTS];
  logic [WIDTH-1:0]     dout   [NUM_SLOTS];

  tdm_slot_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .sel         (sel),
    .wr_en       (wr_en),
    .commit      (commit),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow[i] <= '0;
        dout[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en[i])
          shadow[i] <= in_data;
      end
      // the slot-7 word is still on in_data at commit, so bypass the shadow
      if (commit) begin
        for (int i = 0; i < NUM_SLOTS; i++)
          dout[i] <= wr_en[i] ? in_data : shadow[i];
      end
    end
  end

  assign data0 = dout[0];
  assign data1 = dout[1];
  assign data2 = dout[2];
  assign data3 = dout[3];
  assign data4 = dout[4];
  assign data5 = dout[5];
  assign data6 = dout[6];
  assign data7 = dout[7];

endmodule

// File: doc/tdm_demux_8x8.md
Name: tdm_demux_8x8

Overview:
- Receive end of the 8-channel byte multiplex: takes a time-division stream of WIDTH-bit words (one channel per slot, slot 0 flagged by start-of-frame) and distributes them back onto eight parallel channel outputs.
- Collects a full frame in a shadow buffer, then commits all eight channels atomically with a one-cycle frame_valid strobe.
- Sits after the link that serialises the mux_8x8 sources.
- Detects short frames and stray data.

Parameters:
- WIDTH, 8, bit width of each channel word and of in_data.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_sof qualified this cycle.
- in_sof  input  1  marks slot-0 word; ignored when in_valid=0.
- in_data  input  WIDTH  slot word.
- data0..data7  output  WIDTH each  committed channel values (registered).
- frame_valid  output  1  one-cycle pulse, data0..data7 just updated.
- frame_err  output  1  one-cycle pulse, frame aborted.
- sel  output  3  slot index the next accepted non-SOF word will fill (registered).

Behaviour:
- Reset: synchronous, active-high. At rst=1 on a clk edge: data0..data7=0, shadow buffer=0, frame_valid=0, frame_err=0, sel=0, state=IDLE. rst dominates all inputs. Reset mid-frame discards the partial frame with no pulse.
- State IDLE:
  - in_valid & in_sof: store in_data in shadow[0], sel<=1, go COLLECT.
  - in_valid & !in_sof: word dropped, frame_err<=1 for one cycle, stay IDLE.
  - in_valid=0: hold.
- State COLLECT (sel = 1..7):
  - in_valid & !in_sof: store in shadow[sel], sel<=sel+1.
    - If sel was 7: copy shadow[0..6] plus this word to data0..data7, frame_valid<=1, sel<=0, go IDLE.
  - in_valid & in_sof (short frame): frame_err<=1. The word starts a new frame: shadow[0]<=in_data, sel<=1, stay COLLECT. No commit.
  - in_valid=0: hold (gaps allowed, no timeout).
- Latency: data0..data7 and frame_valid change on the clk edge that accepts the slot-7 word, visible the following cycle.
- Back-to-back frames: SOF on the cycle immediately after slot 7 is accepted from IDLE, so throughput is 1 word/cycle with no bubble.
- data0..data7 hold their last committed frame indefinitely. A partial or aborted frame never alters them.
- frame_valid and frame_err are never high in the same cycle. Both are pulses, deasserted the next cycle unless re-triggered.
- sel wraps 7->0 only via commit. It never increments past 7.

Decomposition:
- Shared package tdm_pkg:
  - Localparam NUM_SLOTS=8, SLOT_W=3.
  - State enum/encoding (IDLE=0, COLLECT=1).
- Sub-module tdm_slot_ctrl: owns the FSM, the sel counter and the pulse generation.
  - Outputs: per-slot write enable and commit strobe.
- Top level holds the shadow and output registers.

Test Plan:
- Reset: assert rst 2 cycles mid-stream -> all data*=0, sel=0, no pulses. First SOF after release is accepted.
- Full frame: SOF+12, then 34,56,78,aa,bb,cc,dd, consecutive -> one cycle after dd: data0=12, data2=56, data7=dd, frame_valid=1 for exactly one cycle, sel=0.
- Gapped frame: same words with in_valid low 3 cycles between slots 3 and 4 -> identical committed values. data* unchanged until commit.
- Short frame: SOF+12,34,56, then SOF+aa followed by 7 words -> frame_err pulse on restart. Committed data0=aa. Previous data* unchanged before commit.
- Stray data in IDLE: in_valid=1, in_sof=0, 0x55 -> frame_err pulse, word dropped, state stays IDLE.
- Back-to-back: two frames with no gap (second 01..08) -> frame_valid pulses 8 cycles apart. data7=08 after second commit.
